// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the two-requester I2C bus arbiter: instruction codes,
// FSM state encoding and the default watchdog limit.
package i2c_arb_pkg;

  localparam logic [1:0] I2C_START = 2'd0;
  localparam logic [1:0] I2C_STOP  = 2'd1;
  localparam logic [1:0] I2C_READ  = 2'd2;
  localparam logic [1:0] I2C_WRITE = 2'd3;

  // 10 ms at 27 MHz
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 270000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OWN0    = 3'd1,
    ST_OWN1    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

  function automatic logic [1:0] grant_of(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/i2c_arb_watchdog.sv
// Ownership watchdog: counts cycles while a requester holds the bus and flags
// expiry when the count reaches TIMEOUT_CYCLES; any master completion restarts it.
module i2c_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 270000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!active_i || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = active_i && !clear_i && (cnt_q == LIMIT);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Two-requester arbiter in front of one shared I2C master; ownership is locked
// from the first instruction until a STOP completes. Watchdog: I2C_ARB_WATCHDOG_EN.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req0_instruction_i,
  input  logic       req0_enable_i,
  input  logic [7:0] req0_byte_to_send_i,
  output logic [7:0] req0_byte_received_o,
  output logic       req0_complete_o,
  input  logic [1:0] req1_instruction_i,
  input  logic       req1_enable_i,
  input  logic [7:0] req1_byte_to_send_i,
  output logic [7:0] req1_byte_received_o,
  output logic       req1_complete_o,
  output logic [1:0] m_instruction_o,
  output logic       m_enable_o,
  output logic [7:0] m_byte_to_send_o,
  input  logic [7:0] m_byte_received_i,
  input  logic       m_complete_i,
  output logic [1:0] grant_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  // Handshake: a requester holds enable with a stable instruction/byte until it
  // sees its one-cycle complete pulse; enable may drop between instructions
  // without giving up ownership, which ends only after STOP plus enable low.
  arb_state_e state_q;
  logic [1:0] grant_q;
  logic       owner_q;
  logic       last_q;
  logic       sel_active;
  logic       owner_en;
  logic       wd_expire;

  assign sel_active = (state_q == ST_OWN0) || (state_q == ST_OWN1) || (state_q == ST_DRAIN);
  assign owner_en   = owner_q ? req1_enable_i : req0_enable_i;

`ifdef I2C_ARB_WATCHDOG_EN
  i2c_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .active_i (sel_active),
    .clear_i  (m_complete_i),
    .expired_o(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  assign timeout_o            = wd_expire;
  assign grant_o              = grant_q;
  assign state_o              = state_q;
  assign req0_byte_received_o = m_byte_received_i;
  assign req1_byte_received_o = m_byte_received_i;

  always_comb begin
    m_instruction_o  = I2C_START;
    m_enable_o       = 1'b0;
    m_byte_to_send_o = 8'h00;
    req0_complete_o  = 1'b0;
    req1_complete_o  = 1'b0;
    if (sel_active) begin
      if (owner_q) begin
        m_instruction_o  = req1_instruction_i;
        m_enable_o       = req1_enable_i;
        m_byte_to_send_o = req1_byte_to_send_i;
        req1_complete_o  = m_complete_i && !wd_expire;
      end else begin
        m_instruction_o  = req0_instruction_i;
        m_enable_o       = req0_enable_i;
        m_byte_to_send_o = req0_byte_to_send_i;
        req0_complete_o  = m_complete_i && !wd_expire;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // On a tie the requester not served last wins
          if (req0_enable_i && (!req1_enable_i || last_q)) begin
            state_q <= ST_OWN0;
            owner_q <= 1'b0;
            grant_q <= grant_of(1'b0);
          end else if (req1_enable_i) begin
            state_q <= ST_OWN1;
            owner_q <= 1'b1;
            grant_q <= grant_of(1'b1);
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (wd_expire) begin
            state_q <= ST_RELEASE;
            grant_q <= 2'b00;
          end else if (m_complete_i && (m_instruction_o == I2C_STOP)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wd_expire || !owner_en) begin
            state_q <= ST_RELEASE;
            grant_q <= 2'b00;
          end
        end
        ST_RELEASE: begin
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 270000 (10 ms at 27 MHz), watchdog limit in clk_i cycles; range 16..2^20.
REQ-002 SHALL have port clk_i  input  1  system clock, 27 MHz.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports req0_instruction_i / req1_instruction_i  input  2  requester I2C instruction.
REQ-005 SHALL have ports req0_enable_i / req1_enable_i  input  1  requester instruction enable.
REQ-006 SHALL have ports req0_byte_to_send_i / req1_byte_to_send_i  input  8  requester write data.
REQ-007 SHALL have ports req0_byte_received_o / req1_byte_received_o  output  8  read data.
REQ-008 SHALL have ports req0_complete_o / req1_complete_o  output  1  instruction complete, per requester.
REQ-009 SHALL have ports m_instruction_o  output  2, m_enable_o  output  1, m_byte_to_send_o  output  8; these drive the shared i2c master.
REQ-010 SHALL have ports m_byte_received_i  input  8 and m_complete_i  input  1; these come from the shared i2c master.
REQ-011 SHALL have port grant_o  output  2  one-hot current owner; 00 = none.
REQ-012 SHALL have port timeout_o  output  1  one-cycle watchdog abort pulse.

Function
REQ-013 SHALL use instruction encoding START=0, STOP=1, READ=2, WRITE=3.
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1, DRAIN and RELEASE.
REQ-015 SHALL, in IDLE with exactly one reqN_enable_i high, enter OWNN on the next clock edge; grant_o SHALL be registered.
REQ-016 SHALL, in IDLE with both enables high, grant the requester not served last; last_q resets to 1, so req0 wins the first tie.
REQ-017 SHALL, in OWNN, drive m_instruction_o, m_enable_o and m_byte_to_send_o combinationally from requester N.
REQ-018 SHALL, in OWNN, route m_complete_i only to reqN_complete_o; the other requester's complete output is 0.
REQ-019 SHALL drive m_byte_received_i to both reqN_byte_received_o at all times.
REQ-020 SHALL hold ownership across enable toggles between instructions; the lock persists from the first instruction until a STOP completes.
REQ-021 SHALL, on m_complete_i=1 with m_instruction_o=STOP in OWNN, enter DRAIN.
REQ-022 SHALL, in DRAIN, keep the mux selected until reqN_enable_i=0, then enter RELEASE.
REQ-023 SHALL, in RELEASE, force m_enable_o=0 and grant_o=00 for exactly one cycle, update last_q, then return to IDLE.
REQ-024 SHALL drive m_enable_o=0, m_instruction_o=0 and m_byte_to_send_o=0 in IDLE and RELEASE.
REQ-025 SHALL let a request arriving during another owner's lock wait, with no loss; it is granted at the earliest two cycles after RELEASE is entered.
REQ-026 SHALL never switch owners mid-transaction; a second START from the owner before STOP stays passed through.

Reset
REQ-027 SHALL, with rst_ni=0, immediately force state=IDLE, grant_o=00, m_enable_o=0, m_instruction_o=0, m_byte_to_send_o=0, both reqN_complete_o=0, timeout_o=0, last_q=1 and watchdog count=0.
REQ-028 SHALL, on reset during OWNN, drop m_enable_o asynchronously; the slave bus is not repaired, and requesters re-issue START.

Configuration
REQ-029 SHALL, with macro I2C_ARB_WATCHDOG_EN defined, count cycles in OWNN/DRAIN, clearing the count on each m_complete_i.
REQ-030 SHALL, with I2C_ARB_WATCHDOG_EN defined and the count reaching TIMEOUT_CYCLES, pulse timeout_o for one cycle, enter RELEASE, and give reqN_complete_o no completion.
REQ-031 SHALL, without I2C_ARB_WATCHDOG_EN, exclude the counter from compilation and tie timeout_o to 0; ownership then ends only via STOP and DRAIN.

Structure
REQ-032 SHALL place instruction codes, the state encoding and the default TIMEOUT_CYCLES in shared package i2c_arb_pkg.
REQ-033 SHALL place the watchdog counter in sub-module i2c_arb_watchdog, instantiated only under I2C_ARB_WATCHDOG_EN; the mux and FSM stay in-module.

Verification
REQ-034 SHALL cover: req0 runs START, WRITE 0x01, STOP with no req1 activity -> grant_o=01 one cycle after req0_enable_i; m_byte_to_send_o=0x01 during WRITE; RELEASE one cycle after req0_enable_i falls in DRAIN; grant_o=00.
REQ-035 SHALL cover: req0 and req1 assert in the same cycle after reset -> req0 served first; req1 granted two cycles after req0 RELEASE entry; req1_complete_o stays 0 throughout the req0 transaction.
REQ-036 SHALL cover: req1 asserts between req0's READ and STOP (req0 enable low) -> grant_o stays 01 until STOP completes; no req1 instruction reaches the master.
REQ-037 SHALL cover: with I2C_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16, the master never completes -> timeout_o=1 for one cycle at count 16; m_enable_o=0 the next cycle; req0_complete_o never pulses.
REQ-038 SHALL cover: rst_ni low mid-WRITE -> m_enable_o=0 and grant_o=00 the same cycle without a clock edge; after release, req1 alone is granted.
